// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: arbitrates for the memory port and streams an 8-word block into the cache.
// Optional completed-fill counter on fill_count when CACHE_FILL_MISS_CNT_EN is defined.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  mem_grant,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  fsm_busy,
  output logic                  mem_req,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [ADDR_WIDTH-1:0] cache_addr
`ifdef CACHE_FILL_MISS_CNT_EN
  ,
  output logic [15:0]           fill_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                state;
  logic [ADDR_WIDTH-5:0] blk;
  logic [3:0]            issue_cnt;
  logic [2:0]            recv_cnt;
  logic                  in_fill;

  // Word data goes straight from memory to the cache; only the strobes are ours.
  logic unused_ok;
  assign unused_ok = ^{memory_data, miss_address[3:0]};

  assign in_fill          = (state == FILL);
  assign mem_read         = in_fill & mem_grant & ~issue_cnt[3];
  assign write_data_array = in_fill & memory_data_valid;
  assign write_tag_array  = write_data_array & (recv_cnt == 3'd7);
  assign memory_address   = {blk, issue_cnt[2:0], 1'b0};
  assign cache_addr       = {blk, recv_cnt, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blk       <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      fsm_busy  <= 1'b0;
      mem_req   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (miss_detected) begin
          blk       <= miss_address[ADDR_WIDTH-1:4];
          issue_cnt <= '0;
          recv_cnt  <= '0;
          fsm_busy  <= 1'b1;
          mem_req   <= 1'b1;
          state     <= REQ;
        end
        REQ: if (mem_grant) state <= FILL;
        FILL: begin
          // Grant loss only pauses issue; in-flight returns are still written.
          if (mem_read)         issue_cnt <= issue_cnt + 4'd1;
          if (write_data_array) recv_cnt  <= recv_cnt + 3'd1;
          if (write_tag_array) begin
            fsm_busy <= 1'b0;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_FILL_MISS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  fill_count <= '0;
    else if (write_tag_array) fill_count <= fill_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: 4-cycle memory model plus address scoreboard, one task per scenario.
module tb_cache_fill_fsm;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          miss_detected = 1'b0;
  logic [AW-1:0] miss_address = '0;
  logic          mem_grant = 1'b0;
  logic          memory_data_valid = 1'b0;
  logic [15:0]   memory_data = '0;
  logic          fsm_busy, mem_req, mem_read, write_data_array, write_tag_array;
  logic [AW-1:0] memory_address, cache_addr;
`ifdef CACHE_FILL_MISS_CNT_EN
  logic [15:0]   fill_count;
`endif

  cache_fill_fsm #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_grant(mem_grant), .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .mem_req(mem_req), .mem_read(mem_read), .memory_address(memory_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array), .cache_addr(cache_addr)
`ifdef CACHE_FILL_MISS_CNT_EN
    , .fill_count(fill_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_wr_q[$];
  logic spur_vld = 1'b0;
  logic        pv[0:4];
  logic [15:0] pa[0:4];

  // Pipelined memory: a read seen in cycle n returns valid in cycle n+4.
  initial begin
    for (int i = 0; i <= 4; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    forever begin
      @(negedge clk);
      pv[0] = mem_read; pa[0] = memory_address;
      @(posedge clk); #2;
      for (int i = 4; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
      memory_data_valid = pv[4] | spur_vld;
      memory_data       = pa[4] ^ 16'h5A5A;
    end
  end

  // Scoreboard: every read and every data write must match the next expected address.
  initial begin
    logic [AW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && mem_read) begin
        tests++;
        if (exp_rd_q.size() == 0) begin fails++; $display("FAIL rd_extra: read at %04h, none expected", memory_address); end
        else begin
          e = exp_rd_q.pop_front();
          if (memory_address !== e) begin fails++; $display("FAIL rd_addr: got %04h expected %04h", memory_address, e); end
        end
      end
      if (!rst && write_data_array) begin
        tests++;
        if (exp_wr_q.size() == 0) begin fails++; $display("FAIL wr_extra: write at %04h, none expected", cache_addr); end
        else begin
          e = exp_wr_q.pop_front();
          if (cache_addr !== e) begin fails++; $display("FAIL wr_addr: got %04h expected %04h", cache_addr, e); end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one miss from cycle 0 (miss driven) until fsm_busy is seen low again.
  task automatic do_fill(input logic [15:0] addr, input int gdelay, input int drop_at, input int drop_len,
                         input bit chained, input bit noise,
                         output int tag_cyc, output int idle_cyc, output int first_rd,
                         output int ntag, output int nrd, output int nwr, output int req_bad);
    logic [AW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      e = {addr[15:4], 4'(i * 2)};
      exp_rd_q.push_back(e);
      exp_wr_q.push_back(e);
    end
    tag_cyc = -1; idle_cyc = -1; first_rd = -1; ntag = 0; nrd = 0; nwr = 0; req_bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (!(chained && c == 0)) begin @(posedge clk); #1; end
      miss_detected = (c == 0) || (noise && c >= 3 && c <= 10 && c[0]);
      miss_address  = (c == 0 || !noise) ? addr : (addr ^ 16'hFFF0);
      mem_grant     = (c >= 1 + gdelay) &&
                      !(c >= 2 + gdelay + drop_at && c < 2 + gdelay + drop_at + drop_len);
      if (chained && c == 0) #1; else @(negedge clk);
      if (mem_read) begin nrd++; if (first_rd < 0) first_rd = c; end
      if (write_data_array) nwr++;
      if (write_tag_array) begin ntag++; tag_cyc = c; end
      if (fsm_busy !== mem_req) req_bad++;
      if (c > 0 && !fsm_busy) begin idle_cyc = c; break; end
    end
    miss_detected = 1'b0;
    mem_grant     = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({fsm_busy, mem_req, mem_read, write_data_array, write_tag_array} !== 5'b0 ||
        memory_address !== '0 || cache_addr !== '0) begin
      fails++;
      $display("FAIL reset_outputs: strobes=%b maddr=%04h caddr=%04h expected all 0",
               {fsm_busy, mem_req, mem_read, write_data_array, write_tag_array}, memory_address, cache_addr);
    end
`ifdef CACHE_FILL_MISS_CNT_EN
    tests++;
    if (fill_count !== 16'd0) begin fails++; $display("FAIL reset_fill_count: got %0d expected 0", fill_count); end
`endif
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests++;
    if (fsm_busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b expected 0", fsm_busy); end
  endtask

  task automatic test_basic_fill;
    int tc, ic, fr, nt, nr, nw, rb;
    do_fill(16'h1234, 0, 0, 0, 1'b0, 1'b0, tc, ic, fr, nt, nr, nw, rb);
    tests++; if (fr !== 2)  begin fails++; $display("FAIL basic_first_read: cycle %0d expected 2", fr); end
    tests++; if (tc !== 13) begin fails++; $display("FAIL basic_tag_cycle: cycle %0d expected 13", tc); end
    tests++; if (nt !== 1)  begin fails++; $display("FAIL basic_tag_count: %0d expected 1", nt); end
    tests++; if (ic !== 14) begin fails++; $display("FAIL basic_idle_cycle: cycle %0d expected 14", ic); end
    tests++; if (nr !== 8 || nw !== 8) begin fails++; $display("FAIL basic_counts: reads %0d writes %0d expected 8/8", nr, nw); end
    tests++; if (rb !== 0)  begin fails++; $display("FAIL basic_req_busy: %0d cycles with mem_req!=fsm_busy expected 0", rb); end
  endtask

  task automatic test_grant_wait;
    int tc, ic, fr, nt, nr, nw, rb;
    do_fill(16'h7F08, 5, 0, 0, 1'b0, 1'b0, tc, ic, fr, nt, nr, nw, rb);
    tests++; if (fr !== 7)  begin fails++; $display("FAIL wait_first_read: cycle %0d expected 7", fr); end
    tests++; if (tc !== 18) begin fails++; $display("FAIL wait_tag_cycle: cycle %0d expected 18", tc); end
    tests++; if (ic !== 19) begin fails++; $display("FAIL wait_idle_cycle: cycle %0d expected 19", ic); end
    tests++; if (rb !== 0)  begin fails++; $display("FAIL wait_req_busy: %0d cycles with mem_req!=fsm_busy expected 0", rb); end
  endtask

  task automatic test_grant_drop;
    int tc, ic, fr, nt, nr, nw, rb;
    do_fill(16'hC3A0, 0, 4, 3, 1'b0, 1'b0, tc, ic, fr, nt, nr, nw, rb);
    tests++; if (nr !== 8 || nw !== 8) begin fails++; $display("FAIL drop_counts: reads %0d writes %0d expected 8/8", nr, nw); end
    tests++; if (tc !== 16) begin fails++; $display("FAIL drop_tag_cycle: cycle %0d expected 16", tc); end
    tests++; if (ic !== 17) begin fails++; $display("FAIL drop_idle_cycle: cycle %0d expected 17", ic); end
    tests++; if (rb !== 0)  begin fails++; $display("FAIL drop_req_held: %0d cycles with mem_req!=fsm_busy expected 0", rb); end
  endtask

  task automatic test_spurious;
    int tc, ic, fr, nt, nr, nw, rb;
    logic [AW-1:0] ca0;
    @(negedge clk);
    ca0 = cache_addr;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; spur_vld = 1'b1;
      @(negedge clk);
      tests++;
      if (write_data_array !== 1'b0 || fsm_busy !== 1'b0 || cache_addr !== ca0) begin
        fails++;
        $display("FAIL idle_valid: wr=%b busy=%b caddr=%04h expected 0/0/%04h", write_data_array, fsm_busy, cache_addr, ca0);
      end
    end
    @(posedge clk); #1; spur_vld = 1'b0;
    @(negedge clk);
    tests++;
    if (cache_addr !== ca0 || fsm_busy !== 1'b0) begin
      fails++; $display("FAIL idle_after_valid: caddr=%04h busy=%b expected %04h/0", cache_addr, fsm_busy, ca0);
    end
    do_fill(16'h8E50, 0, 0, 0, 1'b0, 1'b1, tc, ic, fr, nt, nr, nw, rb);
    tests++; if (tc !== 13 || ic !== 14) begin fails++; $display("FAIL noise_timing: tag %0d idle %0d expected 13/14", tc, ic); end
    tests++; if (nw !== 8 || nt !== 1) begin fails++; $display("FAIL noise_counts: writes %0d tags %0d expected 8/1", nw, nt); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (fsm_busy !== 1'b0) begin fails++; $display("FAIL noise_retrigger: busy=%b expected 0", fsm_busy); end
  endtask

  task automatic test_reset_mid_fill;
    logic [AW-1:0] e;
    int nw = 0, nt = 0, late = 0;
    bit got5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = {12'h4C8, 4'(i * 2)};
      exp_rd_q.push_back(e);
      exp_wr_q.push_back(e);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      miss_detected = (c == 0);
      miss_address  = 16'h4C8B;
      mem_grant     = (c >= 1);
      @(negedge clk);
      if (write_data_array) nw++;
      if (write_tag_array) nt++;
      if (nw == 5) begin got5 = 1'b1; break; end
    end
    tests++; if (!got5) begin fails++; $display("FAIL midreset_progress: %0d words written, expected 5", nw); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({fsm_busy, mem_req, mem_read, write_data_array, write_tag_array} !== 5'b0 ||
        memory_address !== '0 || cache_addr !== '0) begin
      fails++;
      $display("FAIL async_reset: strobes=%b maddr=%04h caddr=%04h expected all 0",
               {fsm_busy, mem_req, mem_read, write_data_array, write_tag_array}, memory_address, cache_addr);
    end
    miss_detected = 1'b0; mem_grant = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (write_tag_array || write_data_array || fsm_busy) late++;
    end
    tests++; if (nt !== 0 || late !== 0) begin fails++; $display("FAIL midreset_no_tag: tags %0d late activity %0d expected 0/0", nt, late); end
`ifdef CACHE_FILL_MISS_CNT_EN
    tests++; if (fill_count !== 16'd0) begin fails++; $display("FAIL midreset_fill_count: got %0d expected 0", fill_count); end
`endif
  endtask

  task automatic test_back_to_back;
    int tc, ic, fr, nt, nr, nw, rb;
    do_fill(16'hA5F0, 0, 0, 0, 1'b0, 1'b0, tc, ic, fr, nt, nr, nw, rb);
    tests++; if (ic !== 14) begin fails++; $display("FAIL b2b_first_idle: cycle %0d expected 14", ic); end
    do_fill(16'h3318, 0, 0, 0, 1'b1, 1'b0, tc, ic, fr, nt, nr, nw, rb);
    tests++; if (tc !== 13 || ic !== 14) begin fails++; $display("FAIL b2b_second_timing: tag %0d idle %0d expected 13/14", tc, ic); end
    tests++; if (nw !== 8) begin fails++; $display("FAIL b2b_second_writes: %0d expected 8", nw); end
`ifdef CACHE_FILL_MISS_CNT_EN
    tests++; if (fill_count !== 16'd2) begin fails++; $display("FAIL b2b_fill_count: got %0d expected 2", fill_count); end
`endif
    tests++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d reads %0d writes left, expected 0", exp_rd_q.size(), exp_wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_grant_wait();
    test_grant_drop();
    test_spurious();
    test_reset_mid_fill();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
